// File: rtl/sram_rr_arbiter_2p.sv
// Two-requester round-robin front end for a single-port SRAM macro with a
// one-cycle registered read; read data returns to the issuing requester.
module sram_rr_arbiter_2p #(
  parameter int ADDR_WIDTH  = 6,
  parameter int DATA_WIDTH  = 32,
  parameter int WMASK_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,

  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic                   req0_we,
  input  logic [WMASK_WIDTH-1:0] req0_wmask,
  input  logic [ADDR_WIDTH-1:0]  req0_addr,
  input  logic [DATA_WIDTH-1:0]  req0_wdata,
  output logic                   rsp0_valid,
  output logic [DATA_WIDTH-1:0]  rsp0_rdata,

  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic                   req1_we,
  input  logic [WMASK_WIDTH-1:0] req1_wmask,
  input  logic [ADDR_WIDTH-1:0]  req1_addr,
  input  logic [DATA_WIDTH-1:0]  req1_wdata,
  output logic                   rsp1_valid,
  output logic [DATA_WIDTH-1:0]  rsp1_rdata,

  output logic                   sram_we,
  output logic [WMASK_WIDTH-1:0] sram_wmask,
  output logic [ADDR_WIDTH-1:0]  sram_addr,
  output logic [DATA_WIDTH-1:0]  sram_din,
  input  logic [DATA_WIDTH-1:0]  sram_dout
);

  localparam int NREQ = 2;

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_we;
  logic [WMASK_WIDTH-1:0] req_wmask [NREQ];
  logic [ADDR_WIDTH-1:0]  req_addr  [NREQ];
  logic [DATA_WIDTH-1:0]  req_wdata [NREQ];

  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        rsp_valid;
  logic [DATA_WIDTH-1:0]  rsp_rdata [NREQ];

  logic                   prio_q, prio_d;
  logic [NREQ-1:0]        rd_pend_q, rd_pend_d;

  assign req_valid    = {req1_valid, req0_valid};
  assign req_we       = {req1_we, req0_we};
  assign req_wmask[0] = req0_wmask;
  assign req_wmask[1] = req1_wmask;
  assign req_addr[0]  = req0_addr;
  assign req_addr[1]  = req1_addr;
  assign req_wdata[0] = req0_wdata;
  assign req_wdata[1] = req1_wdata;

  // Ties go to prio_q; nothing is granted while reset is held.
  always_comb begin
    gnt = '0;
    if (!rst) begin
      if (req_valid[0] && (!req_valid[1] || !prio_q)) begin
        gnt[0] = 1'b1;
      end else if (req_valid[1]) begin
        gnt[1] = 1'b1;
      end
    end
  end

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  // Idle cycles present an all-zero dummy read whose data is never used.
  always_comb begin
    sram_we    = 1'b0;
    sram_wmask = '0;
    sram_addr  = '0;
    sram_din   = '0;
    if (gnt[0]) begin
      sram_we    = req_we[0];
      sram_wmask = req_wmask[0];
      sram_addr  = req_addr[0];
      sram_din   = req_wdata[0];
    end else if (gnt[1]) begin
      sram_we    = req_we[1];
      sram_wmask = req_wmask[1];
      sram_addr  = req_addr[1];
      sram_din   = req_wdata[1];
    end
  end

  always_comb begin
    prio_d = prio_q;
    if (gnt[0]) begin
      prio_d = 1'b1;
    end else if (gnt[1]) begin
      prio_d = 1'b0;
    end
    rd_pend_d = gnt & ~req_we;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q    <= 1'b0;
      rd_pend_q <= '0;
    end else begin
      prio_q    <= prio_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  // Macro output is gated so an unread or uninitialised word never leaks out.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_rsp
    assign rsp_valid[gi] = rd_pend_q[gi];
    assign rsp_rdata[gi] = rd_pend_q[gi] ? sram_dout : '0;
  end

  assign rsp0_valid = rsp_valid[0];
  assign rsp1_valid = rsp_valid[1];
  assign rsp0_rdata = rsp_rdata[0];
  assign rsp1_rdata = rsp_rdata[1];

endmodule

// File: doc/sram_rr_arbiter_2p.md
Name: sram_rr_arbiter_2p

Overview:
- Shares one single-port SRAM22 macro (sramgen_sram_64x32m4w8-class: clk/we/wmask/addr/din/dout, one-cycle registered read) between two requesters.
- Round-robin arbitration; at most one access issued per cycle.
- Read data is routed back to the issuing requester one cycle later with a valid pulse.
- Sits between two bus masters (e.g. core fetch port and DMA port) and the macro instance.

Parameters:
- ADDR_WIDTH, 6, SRAM word address width.
- DATA_WIDTH, 32, SRAM word width.
- WMASK_WIDTH, 4, byte-lane write-mask width (DATA_WIDTH/8).

Ports:
- clk  in  1  single clock; all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 access request.
- req0_ready  out  1  requester 0 access accepted this cycle.
- req0_we  in  1  1 = write, 0 = read.
- req0_wmask  in  WMASK_WIDTH  byte-lane enables for writes.
- req0_addr  in  ADDR_WIDTH  word address.
- req0_wdata  in  DATA_WIDTH  write data.
- rsp0_valid  out  1  read data valid for requester 0.
- rsp0_rdata  out  DATA_WIDTH  read data for requester 0.
- req1_* / rsp1_*  same set as requester 0, for requester 1.
- sram_we  out  1  to macro we.
- sram_wmask  out  WMASK_WIDTH  to macro wmask.
- sram_addr  out  ADDR_WIDTH  to macro addr.
- sram_din  out  DATA_WIDTH  to macro din.
- sram_dout  in  DATA_WIDTH  from macro dout.

Behaviour:
- State:
  - prio: 1 bit; requester with priority on a tie; reset 0.
  - rd_pend[1:0]: read issued last cycle, one-hot; reset 0.
- Grant is combinational each cycle:
  - Only reqK_valid high -> grant K.
  - Both high -> grant prio.
  - Neither high -> no grant.
- reqK_ready = grantK. Ready is not registered; a transfer occurs when valid && ready in the same cycle.
- Requesters hold all req fields stable while valid is high and ready is low.
- Macro drive, combinational mux:
  - On grant: sram_* = granted requester's fields; sram_we = reqK_we.
  - Idle: sram_we = 0, sram_wmask = 0, sram_addr = 0, sram_din = 0. This is a harmless dummy read; its dout is ignored.
- prio update on posedge, only when a grant occurs: prio <= ~granted index. A single requester alone keeps winning; the other wins the next tie.
- Read latency is 1 cycle:
  - A read granted in cycle N sets rd_pend[K] at the N->N+1 edge.
  - rspK_valid = rd_pend[K] in cycle N+1.
  - rspK_rdata = sram_dout in that cycle, passed through unregistered.
  - Back-to-back reads give back-to-back responses; reads can alternate K every cycle.
- rspK_rdata when rspK_valid is 0: drive 0, by gating with rd_pend[K]. Do not pass the macro's X.
- Writes produce no response. wmask = 0 writes are legal no-ops but still consume the slot.
- No response backpressure: the requester must accept rspK_valid in the cycle it is asserted.
- Read-after-write to the same address in consecutive cycles (either requester) returns the new data, since the macro commits the write at edge N.
- Reset:
  - Asynchronous assert clears prio and rd_pend immediately; rsp0_valid = rsp1_valid = 0 at once.
  - While rst is high, readys = 0 and sram_we = 0.
  - A read granted in the cycle before reset is dropped; no response after deassertion.
  - First cycle after deassertion: normal arbitration with prio = 0.

Test Plan:
- Reset, then idle: readys = 0, sram_we = 0, rsp valids = 0, rsp rdata = 0 for 5 cycles.
- Req0 writes addr 5 = 0xDEADBEEF, wmask 4'hF; then req0 reads addr 5 -> rsp0_valid one cycle after the read grant, rsp0_rdata = 0xDEADBEEF; rsp1_valid stays 0.
- Both hold valid reads (req0 addr 1, req1 addr 2, preloaded 0x11/0x22) for 4 cycles:
  - grants alternate 0,1,0,1;
  - responses alternate rsp0 = 0x11, rsp1 = 0x22 each one cycle after grant.
- Byte mask: write addr 3 = 0xAABBCCDD (mask F), then 0x11223344 with mask 4'b0101 -> read returns 0xAA22CC44.
- Req1 alone for 3 grants, then both valid -> req0 wins the tie (prio = 0 after each req1 grant).
- Assert rst the same cycle a read is granted -> no rsp after deassertion; prio = 0; next tie grants req0.
